vga_timing_regbank: RTL and testbench
=====================================

VGA_TIMING_REGBANK -- requirements
Module: vga_timing_regbank

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CLK_DIV, 4, CLK cycles per pixel (minimum 2)
- SYNC_POL, 0, sync active level
- N_REGS, 16, register-bank depth (power of 2, 2..256)
- ADDR_PORT, 8'd40, pointer port
- DATA_PORT, 8'd41, data port
- STATUS_PORT, 8'd2, status port

REQ-002 Ports SHALL be, as name / direction / width / meaning:
- CLK / in / 1 / single clock
- RESET / in / 1 / asynchronous active-low reset
- Port_ID / in / 8 / microcontroller port address
- IN_DATA / in / 8 / write data
- Read_Strobe / in / 1 / read strobe
- Write_Strobe / in / 1 / write strobe
- OUT_DATA / out / 8 / read data
- HSync / out / 1 / horizontal sync
- VSync / out / 1 / vertical sync
- Video_On / out / 1 / visible-area flag
- Pixel_En / out / 1 / one-CLK pixel tick
- Frame_Start / out / 1 / one-CLK pulse at PosX=0, PosY=0
- PosX / out / 10 / pixel column
- PosY / out / 10 / line number
- Reg_Addr_Rd / in / log2(N_REGS) / display-side bank index
- Reg_Data_Rd / out / 8 / active-bank byte at Reg_Addr_Rd, combinational

Function
REQ-003 Pixel_En SHALL pulse high for one CLK every CLK_DIV cycles; the first pulse SHALL occur CLK_DIV cycles after reset release.
REQ-004 The h counter SHALL advance on Pixel_En over 0..H_TOTAL-1 (H_TOTAL = sum of H params) and wrap to 0; the v counter SHALL advance on h wrap over 0..V_TOTAL-1 and wrap to 0.
REQ-005 HSync SHALL equal SYNC_POL while h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~SYNC_POL; VSync SHALL follow the same rule on v.
REQ-006 Video_On SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE; PosX=h, PosY=v.
REQ-007 HSync, VSync, Video_On, PosX, PosY and Frame_Start SHALL be registered and SHALL all be mutually aligned, one CLK after the counter update.
REQ-008 Strobes SHALL be edge-detected: exactly one access per low-to-high transition, acted on in the first cycle the strobe is sampled high.
REQ-009 A write to ADDR_PORT SHALL load the pointer with IN_DATA modulo N_REGS.
REQ-010 A write to DATA_PORT SHALL store IN_DATA into shadow[pointer], set the dirty flag, and increment the pointer, wrapping from N_REGS-1 to 0.
REQ-011 A commit SHALL occur in the cycle where v becomes V_ACTIVE and h=0 (start of vblank), only if dirty=1.
  - Commit copies all of shadow into active in one cycle and clears dirty.
REQ-012 If a data write coincides with the commit cycle:
  - active SHALL receive the pre-write shadow.
  - The written byte SHALL land in shadow.
  - dirty SHALL end at 1.
REQ-013 Reads SHALL latch OUT_DATA on the cycle after the read edge, and OUT_DATA SHALL hold until the next read:
  - STATUS_PORT returns {5'b0, dirty, VSync==SYNC_POL, v>=V_ACTIVE}.
  - ADDR_PORT returns the pointer.
  - DATA_PORT returns shadow[pointer] without increment.
  - Any other port returns 8'h00.
REQ-014 Writes to ports other than ADDR_PORT and DATA_PORT SHALL be ignored; reads SHALL never alter state.

Reset
REQ-015 While RESET=0, the following SHALL hold:
  - Counters, pointer, shadow, active, dirty, OUT_DATA, PosX, PosY, Video_On, Pixel_En and Frame_Start are 0.
  - HSync and VSync are ~SYNC_POL.
  - Strobe edge detectors are cleared.
REQ-016 Reset asserted mid-frame or mid-access SHALL take effect immediately, with no partial commit.

Verification
REQ-017 Timing at defaults: after release, Frame_Start pulses every 1,680,000 CLKs (800 × 525 × 4).
  - HSync is low for 384 CLKs per line, starting at PosX=656.
  - VSync is low for 2 lines, starting at PosY=490.
REQ-018 Write burst: ADDR_PORT←4, then DATA_PORT←8'h16, 8'h45 during active video.
  - Reg_Data_Rd at indices 4 and 5 stays 0 until PosY=480.
  - It then reads 8'h16 and 8'h45; the STATUS bit2 sequence is 1 → 0.
REQ-019 Pointer wrap: ADDR_PORT←15, then three DATA_PORT writes.
  - They land in shadow[15], shadow[0] and shadow[1].
  - A subsequent ADDR_PORT read returns 2.
REQ-020 Commit collision: a data write to index 3 (8'hAA) in the commit cycle, while shadow[2] is pending.
  - Active[2] is updated; active[3] is unchanged; dirty=1.
  - Active[3]=8'hAA after the next vblank.
REQ-021 Status read during vertical sync (PosY=491): OUT_DATA=8'h03 with dirty=0.
  - A read of port 8'd7 returns 8'h00.
REQ-022 A Write_Strobe held high for 5 CLKs SHALL produce one write and one pointer increment.
  - RESET asserted mid-burst clears the pointer and dirty, and HSync/VSync return to 1 immediately.

Source files
------------

// File: rtl/vga_timing_regbank.sv
// VGA timing generator with a double-buffered, microcontroller-written register bank.
// The host writes a pointer/data port pair into a shadow bank. The display-side active bank
// is refreshed from the shadow in one cycle at the start of vertical blanking, and only when
// the shadow holds unsent changes.
module vga_timing_regbank #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned CLK_DIV     = 4,
  parameter logic        SYNC_POL    = 1'b0,
  parameter int unsigned N_REGS      = 16,
  parameter logic [7:0]  ADDR_PORT   = 8'd40,
  parameter logic [7:0]  DATA_PORT   = 8'd41,
  parameter logic [7:0]  STATUS_PORT = 8'd2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [7:0]                Port_ID,
  input  logic [7:0]                IN_DATA,
  input  logic                      Read_Strobe,
  input  logic                      Write_Strobe,
  output logic [7:0]                OUT_DATA,
  output logic                      HSync,
  output logic                      VSync,
  output logic                      Video_On,
  output logic                      Pixel_En,
  output logic                      Frame_Start,
  output logic [9:0]                PosX,
  output logic [9:0]                PosY,
  input  logic [$clog2(N_REGS)-1:0] Reg_Addr_Rd,
  output logic [7:0]                Reg_Data_Rd
);

  localparam int unsigned AW = $clog2(N_REGS);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]    HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0]    H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]    V_ACT_LAST = 10'(V_ACTIVE - 1);

  // Timing state
  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, pix_en_d;
  logic          upd_q, upd_d;       // counters were updated on the previous edge
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          h_wrap, commit;

  // Registered display outputs
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          video_on_q, video_on_d, frame_start_q, frame_start_d;
  logic [9:0]    posx_q, posx_d, posy_q, posy_d;

  // Host interface and register banks
  logic          wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
  logic          wr_pulse, rd_pulse;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          dirty_q, dirty_d;
  logic [7:0]    out_q, out_d;
  logic [7:0]    shadow_q [N_REGS];
  logic [7:0]    shadow_d [N_REGS];
  logic [7:0]    active_q [N_REGS];
  logic [7:0]    active_d [N_REGS];

  // Pixel divider and h/v counters; commit fires on the update that enters vblank
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    pix_en_d = (div_q == DIV_LAST);
    upd_d    = pix_en_q;
    h_wrap   = (h_q == H_LAST);
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en_q) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    commit = pix_en_q && h_wrap && (v_q == V_ACT_LAST) && dirty_q;
  end

  // Display outputs decoded from the counters, one cycle behind them
  always_comb begin
    hsync_d       = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (h_q < H_ACT) && (v_q < V_ACT);
    posx_d        = h_q;
    posy_d        = v_q;
    frame_start_d = upd_q && (h_q == '0) && (v_q == '0);
  end

  // Host port decode, shadow writes, bank commit and read-data latch
  always_comb begin
    wr_prev_d = Write_Strobe;
    rd_prev_d = Read_Strobe;
    wr_pulse  = Write_Strobe && !wr_prev_q;
    rd_pulse  = Read_Strobe && !rd_prev_q;
    ptr_d     = ptr_q;
    dirty_d   = dirty_q;
    out_d     = out_q;
    shadow_d  = shadow_q;
    active_d  = active_q;

    // Commit reads shadow_q, so a write in the same cycle is not included but survives as dirty
    if (commit) begin
      active_d = shadow_q;
      dirty_d  = 1'b0;
    end

    if (wr_pulse) begin
      if (Port_ID == ADDR_PORT) begin
        ptr_d = IN_DATA[AW-1:0];
      end else if (Port_ID == DATA_PORT) begin
        shadow_d[ptr_q] = IN_DATA;
        dirty_d         = 1'b1;
        ptr_d           = ptr_q + AW'(1);
      end
    end

    if (rd_pulse) begin
      if (Port_ID == STATUS_PORT) begin
        out_d = {5'b0, dirty_q, vsync_q == SYNC_POL, posy_q >= V_ACT};
      end else if (Port_ID == ADDR_PORT) begin
        out_d = 8'(ptr_q);
      end else if (Port_ID == DATA_PORT) begin
        out_d = shadow_q[ptr_q];
      end else begin
        out_d = 8'h00;
      end
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      upd_q         <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      posx_q        <= '0;
      posy_q        <= '0;
      wr_prev_q     <= 1'b0;
      rd_prev_q     <= 1'b0;
      ptr_q         <= '0;
      dirty_q       <= 1'b0;
      out_q         <= '0;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      upd_q         <= upd_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      posx_q        <= posx_d;
      posy_q        <= posy_d;
      wr_prev_q     <= wr_prev_d;
      rd_prev_q     <= rd_prev_d;
      ptr_q         <= ptr_d;
      dirty_q       <= dirty_d;
      out_q         <= out_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign OUT_DATA    = out_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign Video_On    = video_on_q;
  assign Pixel_En    = pix_en_q;
  assign Frame_Start = frame_start_q;
  assign PosX        = posx_q;
  assign PosY        = posy_q;
  assign Reg_Data_Rd = active_q[Reg_Addr_Rd];

endmodule

// File: tb/tb_vga_timing_regbank.sv
// Self-checking bench for vga_timing_regbank using a small raster and an arithmetic model
// of raster position versus clock edges since reset release.
module tb_vga_timing_regbank;

  localparam int unsigned HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int unsigned VA = 6, VF = 1, VSW = 2, VB = 1;
  localparam int unsigned DIV = 3, NR = 16;
  localparam int unsigned HT = HA + HF + HSW + HB;
  localparam int unsigned VT = VA + VF + VSW + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned HS0 = HA + HF, HS1 = HA + HF + HSW;
  localparam int unsigned VS0 = VA + VF, VS1 = VA + VF + VSW;
  localparam logic [7:0] P_ADDR = 8'd40, P_DATA = 8'd41, P_STAT = 8'd2;
  localparam int unsigned BOUND = 3 * FRAME * DIV;

  logic       CLK, RESET;
  logic [7:0] Port_ID, IN_DATA, OUT_DATA, Reg_Data_Rd;
  logic       Read_Strobe, Write_Strobe;
  logic       HSync, VSync, Video_On, Pixel_En, Frame_Start;
  logic [9:0] PosX, PosY;
  logic [3:0] Reg_Addr_Rd;

  int checks = 0;
  int failures = 0;
  int unsigned edges = 0;

  // Behavioural model of the host-visible register state
  logic [7:0] m_shadow [NR];
  logic [7:0] m_active [NR];
  int unsigned m_ptr;
  logic m_dirty, m_rd_prev, m_wr_prev;
  logic [7:0] m_out;

  vga_timing_regbank #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .CLK_DIV(DIV), .SYNC_POL(1'b0), .N_REGS(NR),
    .ADDR_PORT(P_ADDR), .DATA_PORT(P_DATA), .STATUS_PORT(P_STAT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .Port_ID(Port_ID), .IN_DATA(IN_DATA),
    .Read_Strobe(Read_Strobe), .Write_Strobe(Write_Strobe), .OUT_DATA(OUT_DATA),
    .HSync(HSync), .VSync(VSync), .Video_On(Video_On), .Pixel_En(Pixel_En),
    .Frame_Start(Frame_Start), .PosX(PosX), .PosY(PosY),
    .Reg_Addr_Rd(Reg_Addr_Rd), .Reg_Data_Rd(Reg_Data_Rd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pixel updates completed by the end of edge t (first update on edge DIV+1)
  function automatic int unsigned nupd(int unsigned t);
    return (t == 0) ? 0 : (t - 1) / DIV;
  endfunction

  // Raster position shown on the registered outputs after edge t
  function automatic int unsigned out_pos(int unsigned t);
    return (t == 0) ? 0 : nupd(t - 1) % FRAME;
  endfunction

  function automatic logic [24:0] exp_vec(int unsigned t);
    int unsigned p, h, v;
    logic fs, pe;
    if (t == 0) return {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    p  = out_pos(t);
    h  = p % HT;
    v  = p / HT;
    pe = (t >= DIV) && (t % DIV == 0);
    fs = (t >= 2) && (nupd(t - 1) != nupd(t - 2)) && (nupd(t - 1) % FRAME == 0);
    return {10'(h), 10'(v), !(h >= HS0 && h < HS1), !(v >= VS0 && v < VS1),
            (h < HA) && (v < VA), pe, fs};
  endfunction

  function automatic logic [24:0] act_vec();
    return {PosX, PosY, HSync, VSync, Video_On, Pixel_En, Frame_Start};
  endfunction

  task automatic model_clear();
    edges = 0;
    m_ptr = 0;
    m_dirty = 1'b0;
    m_rd_prev = 1'b0;
    m_wr_prev = 1'b0;
    m_out = 8'h00;
    for (int i = 0; i < NR; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
  endtask

  // Apply one clock edge's worth of register-bank rules to the model
  task automatic model_edge();
    int unsigned v, n1, n0;
    if (Read_Strobe && !m_rd_prev) begin
      v = out_pos(edges - 1) / HT;
      if (Port_ID == P_STAT) m_out = {5'b0, m_dirty, (v >= VS0 && v < VS1), v >= VA};
      else if (Port_ID == P_ADDR) m_out = 8'(m_ptr);
      else if (Port_ID == P_DATA) m_out = m_shadow[m_ptr];
      else m_out = 8'h00;
    end
    n1 = nupd(edges);
    n0 = nupd(edges - 1);
    if (n1 != n0 && n1 % FRAME == VA * HT && m_dirty) begin
      m_active = m_shadow;
      m_dirty = 1'b0;
    end
    if (Write_Strobe && !m_wr_prev) begin
      if (Port_ID == P_ADDR) begin
        m_ptr = IN_DATA % NR;
      end else if (Port_ID == P_DATA) begin
        m_shadow[m_ptr] = IN_DATA;
        m_dirty = 1'b1;
        m_ptr = (m_ptr + 1) % NR;
      end
    end
    m_rd_prev = Read_Strobe;
    m_wr_prev = Write_Strobe;
  endtask

  task automatic tick();
    @(posedge CLK);
    edges++;
    model_edge();
    @(negedge CLK);
  endtask

  task automatic access(input bit wr, input logic [7:0] port, input logic [7:0] data,
                        input int hold);
    Port_ID = port;
    IN_DATA = data;
    if (wr) Write_Strobe = 1'b1;
    else Read_Strobe = 1'b1;
    repeat (hold) tick();
    Write_Strobe = 1'b0;
    Read_Strobe = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    Read_Strobe = 1'b0;
    Write_Strobe = 1'b0;
    model_clear();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic wait_pos(input int unsigned v, input int unsigned h);
    int guard = 0;
    while (out_pos(edges) != v * HT + h && guard < BOUND) begin
      tick();
      guard++;
    end
    if (guard >= BOUND) begin
      checks++;
      failures++;
      $display("FAIL wait_pos timeout got=%0d required=%0d", out_pos(edges), v * HT + h);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (act_vec() !== exp_vec(0)) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=%h", act_vec(), exp_vec(0));
    end
    checks++;
    if (OUT_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_out_data got=%h required=00", OUT_DATA);
    end
    for (int i = 0; i < NR; i++) begin
      Reg_Addr_Rd = 4'(i);
      #1;
      checks++;
      if (Reg_Data_Rd !== 8'h00) begin
        failures++;
        $display("FAIL reset_active[%0d] got=%h required=00", i, Reg_Data_Rd);
      end
    end
    @(negedge CLK);
    model_clear();
    RESET = 1'b1;
    access(0, P_ADDR, 8'h00, 1);
    checks++;
    if (OUT_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_pointer got=%h required=00", OUT_DATA);
    end
    access(0, P_STAT, 8'h00, 1);
    checks++;
    if (OUT_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_status got=%h required=00", OUT_DATA);
    end
  endtask

  task automatic test_timing();
    do_reset();
    for (int i = 0; i < 2 * FRAME * DIV + 10; i++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec(edges)) begin
        failures++;
        $display("FAIL timing edge=%0d got=%h required=%h", edges, act_vec(), exp_vec(edges));
      end
    end
  endtask

  task automatic test_random_access();
    logic [7:0] ports [5];
    logic [7:0] port;
    bit wr;
    ports[0] = P_ADDR; ports[1] = P_DATA; ports[2] = P_DATA; ports[3] = P_STAT; ports[4] = 8'd7;
    do_reset();
    for (int k = 0; k < 90; k++) begin
      port = ports[$urandom_range(0, 4)];
      wr = 1'($urandom_range(0, 1));
      access(wr, port, 8'($urandom), $urandom_range(1, 4));
      if (!wr) begin
        checks++;
        if (OUT_DATA !== m_out) begin
          failures++;
          $display("FAIL rand_read port=%0d got=%h required=%h", port, OUT_DATA, m_out);
        end
      end
      Reg_Addr_Rd = 4'($urandom_range(0, NR - 1));
      #1;
      checks++;
      if (Reg_Data_Rd !== m_active[Reg_Addr_Rd]) begin
        failures++;
        $display("FAIL rand_active idx=%0d got=%h required=%h", Reg_Addr_Rd, Reg_Data_Rd,
                 m_active[Reg_Addr_Rd]);
      end
      checks++;
      if (act_vec() !== exp_vec(edges)) begin
        failures++;
        $display("FAIL rand_timing got=%h required=%h", act_vec(), exp_vec(edges));
      end
      repeat ($urandom_range(0, 6)) tick();
    end
  endtask

  task automatic test_burst();
    do_reset();
    wait_pos(1, 0);
    access(1, P_ADDR, 8'd4, 1);
    access(1, P_DATA, 8'h16, 1);
    access(1, P_DATA, 8'h45, 1);
    access(0, P_STAT, 8'h00, 1);
    checks++;
    if (OUT_DATA[2] !== 1'b1) begin
      failures++;
      $display("FAIL burst_dirty_set got=%b required=1", OUT_DATA[2]);
    end
    wait_pos(VA - 1, 0);
    Reg_Addr_Rd = 4'd4;
    #1;
    checks++;
    if (Reg_Data_Rd !== 8'h00) begin
      failures++;
      $display("FAIL burst_pre_commit got=%h required=00", Reg_Data_Rd);
    end
    wait_pos(VA, 0);
    #1;
    checks++;
    if (Reg_Data_Rd !== 8'h16) begin
      failures++;
      $display("FAIL burst_active4 got=%h required=16", Reg_Data_Rd);
    end
    Reg_Addr_Rd = 4'd5;
    #1;
    checks++;
    if (Reg_Data_Rd !== 8'h45) begin
      failures++;
      $display("FAIL burst_active5 got=%h required=45", Reg_Data_Rd);
    end
    access(0, P_STAT, 8'h00, 1);
    checks++;
    if (OUT_DATA[2:0] !== 3'b001) begin
      failures++;
      $display("FAIL burst_status_after got=%b required=001", OUT_DATA[2:0]);
    end
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] d0, d1, d2;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    do_reset();
    access(1, P_ADDR, 8'd15, 1);
    access(1, P_DATA, d0, 1);
    access(1, P_DATA, d1, 1);
    access(1, P_DATA, d2, 1);
    access(0, P_ADDR, 8'h00, 1);
    checks++;
    if (OUT_DATA !== 8'd2) begin
      failures++;
      $display("FAIL wrap_pointer got=%h required=02", OUT_DATA);
    end
    access(1, P_ADDR, 8'd255, 1);
    access(0, P_DATA, 8'h00, 1);
    checks++;
    if (OUT_DATA !== d0) begin
      failures++;
      $display("FAIL wrap_shadow15 got=%h required=%h", OUT_DATA, d0);
    end
    access(0, P_ADDR, 8'h00, 1);
    checks++;
    if (OUT_DATA !== 8'd15) begin
      failures++;
      $display("FAIL wrap_no_read_inc got=%h required=0f", OUT_DATA);
    end
    access(1, P_ADDR, 8'd0, 1);
    access(0, P_DATA, 8'h00, 1);
    checks++;
    if (OUT_DATA !== d1) begin
      failures++;
      $display("FAIL wrap_shadow0 got=%h required=%h", OUT_DATA, d1);
    end
    access(1, P_ADDR, 8'd1, 1);
    access(0, P_DATA, 8'h00, 1);
    checks++;
    if (OUT_DATA !== d2) begin
      failures++;
      $display("FAIL wrap_shadow1 got=%h required=%h", OUT_DATA, d2);
    end
  endtask

  task automatic test_collision();
    logic [7:0] x;
    int unsigned tc;
    x = 8'($urandom_range(1, 255));
    do_reset();
    access(1, P_ADDR, 8'd2, 1);
    access(1, P_DATA, x, 1);
    tc = edges + 2;
    while (!(nupd(tc) != nupd(tc - 1) && nupd(tc) % FRAME == VA * HT)) tc++;
    while (edges < tc - 1) tick();
    Port_ID = P_DATA;
    IN_DATA = 8'hAA;
    Write_Strobe = 1'b1;
    tick();
    Write_Strobe = 1'b0;
    tick();
    Reg_Addr_Rd = 4'd2;
    #1;
    checks++;
    if (Reg_Data_Rd !== x) begin
      failures++;
      $display("FAIL collide_active2 got=%h required=%h", Reg_Data_Rd, x);
    end
    Reg_Addr_Rd = 4'd3;
    #1;
    checks++;
    if (Reg_Data_Rd !== 8'h00) begin
      failures++;
      $display("FAIL collide_active3 got=%h required=00", Reg_Data_Rd);
    end
    access(0, P_STAT, 8'h00, 1);
    checks++;
    if (OUT_DATA[2] !== 1'b1) begin
      failures++;
      $display("FAIL collide_dirty got=%b required=1", OUT_DATA[2]);
    end
    wait_pos(0, 0);
    wait_pos(VA, 0);
    #1;
    checks++;
    if (Reg_Data_Rd !== 8'hAA) begin
      failures++;
      $display("FAIL collide_next_vblank got=%h required=aa", Reg_Data_Rd);
    end
  endtask

  task automatic test_status_vsync();
    do_reset();
    wait_pos(VS0 + 1, 0);
    access(0, P_STAT, 8'h00, 1);
    checks++;
    if (OUT_DATA !== 8'h03) begin
      failures++;
      $display("FAIL status_vsync got=%h required=03", OUT_DATA);
    end
    access(0, 8'd7, 8'h00, 1);
    checks++;
    if (OUT_DATA !== 8'h00) begin
      failures++;
      $display("FAIL other_port_read got=%h required=00", OUT_DATA);
    end
  endtask

  task automatic test_held_strobe_reset();
    logic [7:0] d;
    int guard;
    d = 8'($urandom);
    do_reset();
    access(1, P_ADDR, 8'd5, 1);
    access(1, P_DATA, d, 5);
    access(0, P_ADDR, 8'h00, 1);
    checks++;
    if (OUT_DATA !== 8'd6) begin
      failures++;
      $display("FAIL held_single_inc got=%h required=06", OUT_DATA);
    end
    access(1, P_ADDR, 8'd5, 1);
    access(0, P_DATA, 8'h00, 3);
    checks++;
    if (OUT_DATA !== d) begin
      failures++;
      $display("FAIL held_data got=%h required=%h", OUT_DATA, d);
    end
    guard = 0;
    while (!((out_pos(edges) % HT) >= HS0 && (out_pos(edges) % HT) < HS1 &&
             (out_pos(edges) / HT) >= VS0 && (out_pos(edges) / HT) < VS1) && guard < BOUND) begin
      tick();
      guard++;
    end
    checks++;
    if ({HSync, VSync} !== 2'b00) begin
      failures++;
      $display("FAIL pre_reset_syncs got=%b required=00", {HSync, VSync});
    end
    Port_ID = P_DATA;
    IN_DATA = 8'h77;
    Write_Strobe = 1'b1;
    tick();
    tick();
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (act_vec() !== exp_vec(0)) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h required=%h", act_vec(), exp_vec(0));
    end
    Write_Strobe = 1'b0;
    model_clear();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    access(0, P_ADDR, 8'h00, 1);
    checks++;
    if (OUT_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_clears_pointer got=%h required=00", OUT_DATA);
    end
    access(0, P_STAT, 8'h00, 1);
    checks++;
    if (OUT_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_clears_dirty got=%h required=00", OUT_DATA);
    end
  endtask

  initial begin
    RESET = 1'b0;
    Port_ID = 8'h00;
    IN_DATA = 8'h00;
    Read_Strobe = 1'b0;
    Write_Strobe = 1'b0;
    Reg_Addr_Rd = 4'd0;
    model_clear();
    test_reset();
    test_timing();
    test_random_access();
    test_burst();
    test_pointer_wrap();
    test_collision();
    test_status_vsync();
    test_held_strobe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
